ip_tx_arbiter: RTL and testbench
================================

// Module: ip_tx_arbiter
// PURPOSE
//   Packet-granular round-robin arbiter sharing the IP-layer TX AXI-Stream between two
//   requesters: port 0 (ICMP TX generator) and port 1 (UDP TX path). Sits directly upstream
//   of the IP TX encapsulator. Whole packets are forwarded unbroken, so the IP header user
//   field {len,flag,type,offset,ID} stays paired with its payload. Per-port packet counters
//   are kept for debug.
// PARAMETERS
//   DATA_W  64  tdata width, bits
//   USER_W  56  tuser width: {16 len,3 flag,8 type,13 offset,16 ID}
//   KEEP_W   8  tkeep width (DATA_W/8)
//   CNT_W   16  width of per-port packet counters
// PORTS
//   i_clk             in   1       single clock domain
//   i_rst_n           in   1       asynchronous reset, active-low
//   s0_axis_ip_data   in   DATA_W  port 0 (ICMP) tdata
//   s0_axis_ip_user   in   USER_W  port 0 tuser, meaningful on every beat
//   s0_axis_ip_keep   in   KEEP_W  port 0 tkeep
//   s0_axis_ip_last   in   1       port 0 end of packet
//   s0_axis_ip_valid  in   1       port 0 tvalid
//   s0_axis_ip_ready  out  1       port 0 tready
//   s1_axis_ip_*      as s0_*      port 1 (UDP), same widths and directions
//   m_axis_ip_data    out  DATA_W  tdata to IP TX
//   m_axis_ip_user    out  USER_W  tuser to IP TX
//   m_axis_ip_keep    out  KEEP_W  tkeep to IP TX
//   m_axis_ip_last    out  1       end of packet to IP TX
//   m_axis_ip_valid   out  1       tvalid to IP TX
//   m_axis_ip_ready   in   1       tready from IP TX
//   o_grant           out  2       one-hot current grant; 00 = idle
//   o_pkt_cnt0        out  CNT_W   packets completed from port 0, wraps to 0
//   o_pkt_cnt1        out  CNT_W   packets completed from port 1, wraps to 0
// BEHAVIOUR
//   Reset (i_rst_n=0, async): state IDLE, rr_ptr=0, o_grant=00, counters=0, both s*_ready=0,
//     m_axis_ip_valid=0, m_axis_ip_last=0, data/user/keep=0. Applies mid-packet too: the
//     partial packet is abandoned and the source must restart it after reset.
//   FSM states: IDLE, GNT0, GNT1 (registered).
//   IDLE: s*_ready=0; m_* outputs zero. Next state on the following edge:
//     - only s0 valid -> GNT0; only s1 valid -> GNT1.
//     - both valid -> GNT(rr_ptr). rr_ptr=0 after reset, so port 0 wins the first tie.
//     - neither valid -> stay in IDLE.
//   GNTk: combinational pass-through with zero latency. m_* = sk_*, sk_ready =
//     m_axis_ip_ready, and the other port's ready=0.
//     - Grant is held while sk_valid=0 mid-packet (gaps allowed) and while m_ready=0.
//     - Leaves only on the beat sk_valid & m_ready & sk_last: next state IDLE,
//       rr_ptr <= ~k, o_pkt_cntk <= o_pkt_cntk+1 (mod 2^CNT_W).
//   Arbitration latency: 1 cycle from valid to the first forwarded beat (IDLE->GNT).
//     Back-to-back packets from any source always have exactly one idle bubble between them.
//   o_grant = {state==GNT1, state==GNT0}. Never 11.
//   Valid asserted by the non-granted port: it waits, and its ready stays 0. Its beats are
//     never dropped or reordered.
//   A one-beat packet (valid & last on the first beat) completes in GNTk in a single cycle.
//   The block does not check or modify payload, keep or user.
// TESTING
//   1. Reset, then s0 sends a 5-beat packet (user={16'd5,3'b010,8'd1,13'd0,16'd1}) with
//      m_ready=1 -> grant 01 one cycle after valid, 5 beats identical on m, last on beat 5,
//      then IDLE, o_pkt_cnt0=1.
//   2. s0 and s1 raise valid in the same cycle right after reset -> s0 packet first, one
//      bubble, then the s1 packet. If both stay valid, the order alternates
//      0,1,0,1 (rr_ptr toggles).
//   3. m_ready toggled 1,0,1,0 during an s1 3-beat packet -> each beat accepted only when
//      ready=1, grant held throughout, s0_ready=0 the whole time.
//   4. s0 drops valid for 3 cycles mid-packet while s1 is valid -> grant stays 01 and s1
//      waits until s0 last completes.
//   5. i_rst_n pulsed low during beat 3 of an s1 packet -> same cycle: o_grant=00,
//      m_valid=0, readies 0, counters 0; after release, a fresh s1 packet is arbitrated
//      normally.
//   6. Preload o_pkt_cnt1 to 16'hFFFF via 65535 one-beat s1 packets, then send one more ->
//      counter wraps to 0. Also checks that one-beat packets each complete in one GNT cycle.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// Packet-granular round-robin arbiter: two AXI-Stream IP TX sources onto one sink.
// Latency: 1 cycle IDLE->grant; then zero-latency pass-through; one idle bubble between packets.
// Backpressure: granted source sees m_axis_ip_ready directly; the waiting source sees ready=0.
module ip_tx_arbiter #(
    parameter int DATA_W = 64,
    parameter int USER_W = 56,
    parameter int KEEP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic [DATA_W-1:0] s0_axis_ip_data,
    input  logic [USER_W-1:0] s0_axis_ip_user,
    input  logic [KEEP_W-1:0] s0_axis_ip_keep,
    input  logic              s0_axis_ip_last,
    input  logic              s0_axis_ip_valid,
    output logic              s0_axis_ip_ready,

    input  logic [DATA_W-1:0] s1_axis_ip_data,
    input  logic [USER_W-1:0] s1_axis_ip_user,
    input  logic [KEEP_W-1:0] s1_axis_ip_keep,
    input  logic              s1_axis_ip_last,
    input  logic              s1_axis_ip_valid,
    output logic              s1_axis_ip_ready,

    output logic [DATA_W-1:0] m_axis_ip_data,
    output logic [USER_W-1:0] m_axis_ip_user,
    output logic [KEEP_W-1:0] m_axis_ip_keep,
    output logic              m_axis_ip_last,
    output logic              m_axis_ip_valid,
    input  logic              m_axis_ip_ready,

    output logic [1:0]        o_grant,
    output logic [CNT_W-1:0]  o_pkt_cnt0,
    output logic [CNT_W-1:0]  o_pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t            state;
    logic              rr_ptr;
    logic [1:0]        grant_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;
    logic              done0;
    logic              done1;

    // A packet ends only on the handshake of its last beat.
    assign done0 = (state == GNT0) && s0_axis_ip_valid && m_axis_ip_ready && s0_axis_ip_last;
    assign done1 = (state == GNT1) && s1_axis_ip_valid && m_axis_ip_ready && s1_axis_ip_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            grant_q <= 2'b00;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_axis_ip_valid && (!s1_axis_ip_valid || !rr_ptr)) begin
                        state   <= GNT0;
                        grant_q <= 2'b01;
                    end else if (s1_axis_ip_valid) begin
                        state   <= GNT1;
                        grant_q <= 2'b10;
                    end
                end
                GNT0: begin
                    if (done0) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        rr_ptr  <= 1'b1;
                        cnt0_q  <= cnt0_q + CNT_W'(1);
                    end
                end
                GNT1: begin
                    if (done1) begin
                        state   <= IDLE;
                        grant_q <= 2'b00;
                        rr_ptr  <= 1'b0;
                        cnt1_q  <= cnt1_q + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        m_axis_ip_data   = '0;
        m_axis_ip_user   = '0;
        m_axis_ip_keep   = '0;
        m_axis_ip_last   = 1'b0;
        m_axis_ip_valid  = 1'b0;
        s0_axis_ip_ready = 1'b0;
        s1_axis_ip_ready = 1'b0;
        case (state)
            GNT0: begin
                m_axis_ip_data   = s0_axis_ip_data;
                m_axis_ip_user   = s0_axis_ip_user;
                m_axis_ip_keep   = s0_axis_ip_keep;
                m_axis_ip_last   = s0_axis_ip_last;
                m_axis_ip_valid  = s0_axis_ip_valid;
                s0_axis_ip_ready = m_axis_ip_ready;
            end
            GNT1: begin
                m_axis_ip_data   = s1_axis_ip_data;
                m_axis_ip_user   = s1_axis_ip_user;
                m_axis_ip_keep   = s1_axis_ip_keep;
                m_axis_ip_last   = s1_axis_ip_last;
                m_axis_ip_valid  = s1_axis_ip_valid;
                s1_axis_ip_ready = m_axis_ip_ready;
            end
            default: ;
        endcase
    end

    assign o_grant    = grant_q;
    assign o_pkt_cnt0 = cnt0_q;
    assign o_pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Bench for ip_tx_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_ip_tx_arbiter;
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [63:0] d;
        logic [55:0] u;
        logic [7:0]  kp;
        logic        l;
    } beat_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b1;
    logic [63:0] s0_axis_ip_data = '0, s1_axis_ip_data = '0, m_axis_ip_data;
    logic [55:0] s0_axis_ip_user = '0, s1_axis_ip_user = '0, m_axis_ip_user;
    logic [7:0]  s0_axis_ip_keep = '0, s1_axis_ip_keep = '0, m_axis_ip_keep;
    logic s0_axis_ip_last = 1'b0, s1_axis_ip_last = 1'b0, m_axis_ip_last;
    logic s0_axis_ip_valid = 1'b0, s1_axis_ip_valid = 1'b0, m_axis_ip_valid;
    logic s0_axis_ip_ready, s1_axis_ip_ready;
    logic m_axis_ip_ready = 1'b0;
    logic [1:0] o_grant;
    logic [CNT_W-1:0] o_pkt_cnt0, o_pkt_cnt1;

    int checks = 0;
    int errors = 0;

    beat_t q0[$], q1[$];
    logic en0 = 1'b0, en1 = 1'b0, acc0 = 1'b0, acc1 = 1'b0, nxt_mready = 1'b0;

    ip_tx_arbiter #(.DATA_W(64), .USER_W(56), .KEEP_W(8), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .s0_axis_ip_data(s0_axis_ip_data), .s0_axis_ip_user(s0_axis_ip_user),
        .s0_axis_ip_keep(s0_axis_ip_keep), .s0_axis_ip_last(s0_axis_ip_last),
        .s0_axis_ip_valid(s0_axis_ip_valid), .s0_axis_ip_ready(s0_axis_ip_ready),
        .s1_axis_ip_data(s1_axis_ip_data), .s1_axis_ip_user(s1_axis_ip_user),
        .s1_axis_ip_keep(s1_axis_ip_keep), .s1_axis_ip_last(s1_axis_ip_last),
        .s1_axis_ip_valid(s1_axis_ip_valid), .s1_axis_ip_ready(s1_axis_ip_ready),
        .m_axis_ip_data(m_axis_ip_data), .m_axis_ip_user(m_axis_ip_user),
        .m_axis_ip_keep(m_axis_ip_keep), .m_axis_ip_last(m_axis_ip_last),
        .m_axis_ip_valid(m_axis_ip_valid), .m_axis_ip_ready(m_axis_ip_ready),
        .o_grant(o_grant), .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
    );

    always #5 i_clk = ~i_clk;

    function automatic beat_t mk_beat(input logic last);
        beat_t b;
        b.d  = {$urandom, $urandom};
        b.u  = 56'({$urandom, $urandom});
        b.kp = 8'($urandom);
        b.l  = last;
        return b;
    endfunction

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            if (k == 0) q0.push_back(mk_beat(i == len - 1));
            else        q1.push_back(mk_beat(i == len - 1));
        end
    endtask

    // One clock: sources retire accepted beats, present their queue heads, then settle.
    task automatic cycle();
        beat_t h0, h1;
        @(posedge i_clk);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        s0_axis_ip_valid = en0 && (q0.size() > 0);
        s0_axis_ip_data = h0.d; s0_axis_ip_user = h0.u; s0_axis_ip_keep = h0.kp; s0_axis_ip_last = h0.l;
        s1_axis_ip_valid = en1 && (q1.size() > 0);
        s1_axis_ip_data = h1.d; s1_axis_ip_user = h1.u; s1_axis_ip_keep = h1.kp; s1_axis_ip_last = h1.l;
        m_axis_ip_ready = nxt_mready;
        #4;
        acc0 = s0_axis_ip_valid && s0_axis_ip_ready;
        acc1 = s1_axis_ip_valid && s1_axis_ip_ready;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        q0.delete(); q1.delete();
        en0 = 1'b0; en1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0; nxt_mready = 1'b0;
        s0_axis_ip_valid = 1'b0; s1_axis_ip_valid = 1'b0; m_axis_ip_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        #4;
    endtask

    task automatic drain(input string name);
        nxt_mready = 1'b1; en0 = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) cycle();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL %s_drain: pending beats got %0d/%0d required 0/0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        #3 i_rst_n = 1'b0;
        #1;
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b required 00", o_grant); end
        checks++; if ({m_axis_ip_valid, m_axis_ip_last, s0_axis_ip_ready, s1_axis_ip_ready} !== 4'b0) begin
            errors++; $display("FAIL rst_handshake: got %b required 0000", {m_axis_ip_valid, m_axis_ip_last, s0_axis_ip_ready, s1_axis_ip_ready}); end
        checks++; if ({m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep} !== '0) begin
            errors++; $display("FAIL rst_payload: got %h required 0", {m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep}); end
        checks++; if (o_pkt_cnt0 !== '0 || o_pkt_cnt1 !== '0) begin
            errors++; $display("FAIL rst_counters: got %0d/%0d required 0/0", o_pkt_cnt0, o_pkt_cnt1); end
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        #4;
    endtask

    task automatic test_single_packet();
        beat_t exp[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp[i] = mk_beat(i == 4);
            exp[i].u = {16'd5, 3'b010, 8'd1, 13'd0, 16'd1};
            q0.push_back(exp[i]);
        end
        en0 = 1'b1; nxt_mready = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00 || m_axis_ip_valid !== 1'b0 || s0_axis_ip_ready !== 1'b0) begin
            errors++; $display("FAIL single_arb_cycle: got grant=%b mv=%b rdy=%b required 00/0/0", o_grant, m_axis_ip_valid, s0_axis_ip_ready); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (o_grant !== 2'b01 || m_axis_ip_valid !== 1'b1 || s0_axis_ip_ready !== 1'b1) begin
                errors++; $display("FAIL single_grant beat%0d: got grant=%b mv=%b rdy=%b required 01/1/1", i, o_grant, m_axis_ip_valid, s0_axis_ip_ready); end
            checks++; if ({m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep, m_axis_ip_last} !== exp[i]) begin
                errors++; $display("FAIL single_beat%0d: got %h required %h", i, {m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep, m_axis_ip_last}, exp[i]); end
        end
        en0 = 1'b0;
        cycle();
        checks++; if (o_grant !== 2'b00 || m_axis_ip_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle_after: got grant=%b mv=%b required 00/0", o_grant, m_axis_ip_valid); end
        checks++; if (o_pkt_cnt0 !== CNT_W'(1)) begin errors++; $display("FAIL single_cnt0: got %0d required 1", o_pkt_cnt0); end
    endtask

    task automatic test_tie_round_robin();
        beat_t e0[$], e1[$];
        int i0 = 0, i1 = 0, k;
        beat_t eb;
        do_reset();
        push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2); push_pkt(1, 2);
        e0 = q0; e1 = q1;
        en0 = 1'b1; en1 = 1'b1; nxt_mready = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00 || s0_axis_ip_ready !== 1'b0 || s1_axis_ip_ready !== 1'b0) begin
            errors++; $display("FAIL tie_idle: got grant=%b rdy=%b%b required 00/00", o_grant, s1_axis_ip_ready, s0_axis_ip_ready); end
        for (int p = 0; p < 4; p++) begin
            k = p % 2;
            for (int b = 0; b < 2; b++) begin
                cycle();
                eb = (k == 0) ? e0[i0] : e1[i1];
                if (k == 0) i0++; else i1++;
                checks++; if (o_grant !== ((k == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL tie_order pkt%0d beat%0d: got grant %b required port %0d", p, b, o_grant, k); end
                checks++; if (m_axis_ip_data !== eb.d || m_axis_ip_last !== eb.l) begin
                    errors++; $display("FAIL tie_data pkt%0d beat%0d: got %h/%b required %h/%b", p, b, m_axis_ip_data, m_axis_ip_last, eb.d, eb.l); end
            end
            cycle();
            checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL tie_bubble pkt%0d: got grant %b required 00", p, o_grant); end
        end
        checks++; if (o_pkt_cnt0 !== CNT_W'(2) || o_pkt_cnt1 !== CNT_W'(2)) begin
            errors++; $display("FAIL tie_counts: got %0d/%0d required 2/2", o_pkt_cnt0, o_pkt_cnt1); end
    endtask

    task automatic test_backpressure();
        beat_t b3[$];
        int bidx = 0;
        push_pkt(1, 3);
        b3 = q1;
        en1 = 1'b1; nxt_mready = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL bp_idle: got grant %b required 00", o_grant); end
        push_pkt(0, 2);
        en0 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            nxt_mready = (c % 2 == 0);
            cycle();
            checks++; if (o_grant !== 2'b10 || s0_axis_ip_ready !== 1'b0 || s1_axis_ip_ready !== nxt_mready) begin
                errors++; $display("FAIL bp_grant c%0d: got grant=%b r0=%b r1=%b required 10/0/%b", c, o_grant, s0_axis_ip_ready, s1_axis_ip_ready, nxt_mready); end
            checks++; if (m_axis_ip_valid !== 1'b1 || m_axis_ip_data !== b3[bidx].d) begin
                errors++; $display("FAIL bp_beat c%0d: got %b/%h required 1/%h", c, m_axis_ip_valid, m_axis_ip_data, b3[bidx].d); end
            if (nxt_mready) bidx++;
        end
        nxt_mready = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00 || q1.size() != 0) begin
            errors++; $display("FAIL bp_end: got grant=%b s1 left=%0d required 00/0", o_grant, q1.size()); end
        cycle();
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL bp_next_s0: got grant %b required 01", o_grant); end
        drain("bp");
    endtask

    task automatic test_gap_hold();
        beat_t b4[$];
        en1 = 1'b0; en0 = 1'b1; nxt_mready = 1'b1;
        push_pkt(0, 4);
        b4 = q0;
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL gap_idle: got grant %b required 00", o_grant); end
        push_pkt(1, 2);
        en1 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en0 = !(i >= 2 && i <= 4);
            cycle();
            checks++; if (o_grant !== 2'b01 || s1_axis_ip_ready !== 1'b0) begin
                errors++; $display("FAIL gap_hold c%0d: got grant=%b r1=%b required 01/0", i, o_grant, s1_axis_ip_ready); end
            checks++; if (m_axis_ip_valid !== en0) begin
                errors++; $display("FAIL gap_valid c%0d: got %b required %b", i, m_axis_ip_valid, en0); end
            if (en0) begin
                checks++; if (m_axis_ip_data !== b4[(i < 2) ? i : i - 3].d) begin
                    errors++; $display("FAIL gap_data c%0d: got %h required %h", i, m_axis_ip_data, b4[(i < 2) ? i : i - 3].d); end
            end
        end
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL gap_bubble: got grant %b required 00", o_grant); end
        cycle();
        checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL gap_s1_next: got grant %b required 10", o_grant); end
        drain("gap");
    endtask

    task automatic test_mid_packet_reset();
        beat_t fr[$];
        push_pkt(1, 5);
        en0 = 1'b0; en1 = 1'b1; nxt_mready = 1'b1;
        repeat (4) cycle();
        checks++; if (o_grant !== 2'b10 || m_axis_ip_valid !== 1'b1) begin
            errors++; $display("FAIL mrst_pre: got grant=%b mv=%b required 10/1", o_grant, m_axis_ip_valid); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_grant !== 2'b00 || m_axis_ip_valid !== 1'b0 || m_axis_ip_last !== 1'b0) begin
            errors++; $display("FAIL mrst_out: got grant=%b mv=%b ml=%b required 00/0/0", o_grant, m_axis_ip_valid, m_axis_ip_last); end
        checks++; if (s0_axis_ip_ready !== 1'b0 || s1_axis_ip_ready !== 1'b0 || m_axis_ip_data !== '0) begin
            errors++; $display("FAIL mrst_ready: got r0=%b r1=%b data=%h required 0/0/0", s0_axis_ip_ready, s1_axis_ip_ready, m_axis_ip_data); end
        checks++; if (o_pkt_cnt0 !== '0 || o_pkt_cnt1 !== '0) begin
            errors++; $display("FAIL mrst_cnt: got %0d/%0d required 0/0", o_pkt_cnt0, o_pkt_cnt1); end
        q1.delete(); en1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        #3;
        cycle();
        i_rst_n = 1'b1;
        push_pkt(1, 3);
        fr = q1;
        en1 = 1'b1;
        cycle();
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL mrst_rearb_idle: got grant %b required 00", o_grant); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (o_grant !== 2'b10 || m_axis_ip_data !== fr[i].d || m_axis_ip_last !== fr[i].l) begin
                errors++; $display("FAIL mrst_fresh beat%0d: got %b/%h/%b required 10/%h/%b", i, o_grant, m_axis_ip_data, m_axis_ip_last, fr[i].d, fr[i].l); end
        end
        cycle();
        checks++; if (o_grant !== 2'b00 || o_pkt_cnt1 !== CNT_W'(1)) begin
            errors++; $display("FAIL mrst_done: got grant=%b cnt1=%0d required 00/1", o_grant, o_pkt_cnt1); end
    endtask

    task automatic test_counter_wrap();
        localparam int N = 1 << CNT_W;
        do_reset();
        for (int n = 0; n < N; n++) push_pkt(1, 1);
        en1 = 1'b1; nxt_mready = 1'b1;
        cycle();
        for (int n = 0; n < N; n++) begin
            cycle();
            checks++; if (o_grant !== 2'b10 || m_axis_ip_valid !== 1'b1 || m_axis_ip_last !== 1'b1) begin
                errors++; $display("FAIL wrap_onebeat pkt%0d: got grant=%b mv=%b ml=%b required 10/1/1", n, o_grant, m_axis_ip_valid, m_axis_ip_last); end
            cycle();
            checks++; if (o_grant !== 2'b00 || o_pkt_cnt1 !== CNT_W'((n + 1) % N)) begin
                errors++; $display("FAIL wrap_cnt pkt%0d: got grant=%b cnt1=%0d required 00/%0d", n, o_grant, o_pkt_cnt1, (n + 1) % N); end
        end
    endtask

    // Packet-level reference: an owner holds the link until its last beat is accepted,
    // ties at idle go to the port that did not finish most recently.
    task automatic test_random();
        int owner = -1, prefer = 0, mc0 = 0, mc1 = 0, cyc = 0;
        logic v0, v1, eval, last_own;
        logic [1:0] egr;
        beat_t h0, h1, eb;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            push_pkt(0, $urandom_range(1, 4));
            push_pkt(1, $urandom_range(1, 4));
        end
        while (cyc < 4000 && (q0.size() > 0 || q1.size() > 0 || owner >= 0)) begin
            en0 = (s0_axis_ip_valid && !acc0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            en1 = (s1_axis_ip_valid && !acc1) ? 1'b1 : ($urandom_range(0, 99) < 60);
            nxt_mready = ($urandom_range(0, 99) < 70);
            cycle();
            cyc++;
            v0 = s0_axis_ip_valid; v1 = s1_axis_ip_valid;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            h1 = (q1.size() > 0) ? q1[0] : '0;
            egr  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            eval = (owner == 0) ? v0 : (owner == 1) ? v1 : 1'b0;
            eb   = (owner == 0) ? h0 : (owner == 1) ? h1 : '0;
            checks++; if (o_grant !== egr || m_axis_ip_valid !== eval) begin
                errors++; $display("FAIL rnd_grant cyc%0d: got %b/%b required %b/%b", cyc, o_grant, m_axis_ip_valid, egr, eval); end
            checks++; if ({m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep, m_axis_ip_last} !== eb) begin
                errors++; $display("FAIL rnd_beat cyc%0d: got %h required %h", cyc, {m_axis_ip_data, m_axis_ip_user, m_axis_ip_keep, m_axis_ip_last}, eb); end
            checks++; if (s0_axis_ip_ready !== (owner == 0 && m_axis_ip_ready) || s1_axis_ip_ready !== (owner == 1 && m_axis_ip_ready)) begin
                errors++; $display("FAIL rnd_ready cyc%0d: got %b%b required %b%b", cyc, s1_axis_ip_ready, s0_axis_ip_ready, owner == 1 && m_axis_ip_ready, owner == 0 && m_axis_ip_ready); end
            if (owner < 0) begin
                if (v0 && v1) owner = prefer;
                else if (v0)  owner = 0;
                else if (v1)  owner = 1;
            end else begin
                last_own = (owner == 0) ? h0.l : h1.l;
                if (eval && m_axis_ip_ready && last_own) begin
                    if (owner == 0) mc0++; else mc1++;
                    prefer = 1 - owner;
                    owner = -1;
                end
            end
        end
        checks++; if (q0.size() != 0 || q1.size() != 0 || owner >= 0) begin
            errors++; $display("FAIL rnd_timeout: pending %0d/%0d owner %0d required 0/0/-1", q0.size(), q1.size(), owner); end
        checks++; if (o_pkt_cnt0 !== CNT_W'(mc0) || o_pkt_cnt1 !== CNT_W'(mc1)) begin
            errors++; $display("FAIL rnd_counts: got %0d/%0d required %0d/%0d", o_pkt_cnt0, o_pkt_cnt1, mc0, mc1); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_tie_round_robin();
        test_backpressure();
        test_gap_hold();
        test_mid_packet_reset();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
